// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC front end: default widths, quadrant codes
// and the +/-90 degree angle offsets.
package cordic_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_FRAC_BITS  = 16;

  typedef enum logic [1:0] {
    Q_PASS  = 2'd0,
    Q_POS90 = 2'd1,
    Q_NEG90 = 2'd2
  } quadrant_e;

  localparam logic signed [63:0] DEG90_RAW = 64'sd90;

  // 90 degrees in fixed point with frac_bits fractional bits; callers truncate to their width.
  function automatic logic signed [63:0] pos90_offset(input int unsigned frac_bits);
    return DEG90_RAW <<< frac_bits;
  endfunction

  localparam logic signed [DEF_DATA_WIDTH-1:0] OFFSET_POS90 =
      DEF_DATA_WIDTH'(pos90_offset(DEF_FRAC_BITS));
  localparam logic signed [DEF_DATA_WIDTH-1:0] OFFSET_NEG90 = -OFFSET_POS90;

endpackage

// File: rtl/cordic_pipe_reg.sv
// Single valid/ready register slice; accepts new data whenever it is empty or
// its current contents are being taken downstream in the same cycle.
module cordic_pipe_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             load;

  assign load      = !valid_q || out_ready;
  assign in_ready  = load;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/cordic_pre_rotator.sv
// Folds any input vector into the right half-plane (x >= 0), halves it for
// CORDIC gain headroom and reports the angle offset to add back afterwards.
module cordic_pre_rotator
  import cordic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_x,
  input  logic signed [DATA_WIDTH-1:0] in_y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_x,
  output logic signed [DATA_WIDTH-1:0] out_y,
  output logic signed [DATA_WIDTH-1:0] out_z_offset,
  output logic                         out_zero,
  output logic [15:0]                  out_count
);

  localparam int unsigned S1W = 2 * DATA_WIDTH + 3;
  localparam int unsigned S2W = 3 * DATA_WIDTH + 1;

  localparam logic signed [DATA_WIDTH-1:0] OFF_POS90 = DATA_WIDTH'(pos90_offset(FRAC_BITS));
  localparam logic signed [DATA_WIDTH-1:0] OFF_NEG90 = -OFF_POS90;

  // Stage 1: capture operands and classify the quadrant.
  quadrant_e      quad_in;
  logic           zero_in;
  logic [S1W-1:0] s1_d;
  logic [S1W-1:0] s1_q;
  logic           s1_in_ready;
  logic           s1_valid;
  logic           s2_in_ready;

  always_comb begin
    quad_in = Q_PASS;
    if (in_x[DATA_WIDTH-1]) begin
      quad_in = in_y[DATA_WIDTH-1] ? Q_NEG90 : Q_POS90;
    end
  end

  assign zero_in  = (in_x == '0) && (in_y == '0);
  assign s1_d     = {in_x, in_y, quad_in, zero_in};
  assign in_ready = resetn && s1_in_ready;

  cordic_pipe_reg #(
    .WIDTH(S1W)
  ) u_s1 (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (s1_in_ready),
    .in_data  (s1_d),
    .out_valid(s1_valid),
    .out_ready(s2_in_ready),
    .out_data (s1_q)
  );

  logic signed [DATA_WIDTH-1:0] s1_x;
  logic signed [DATA_WIDTH-1:0] s1_y;
  quadrant_e                    s1_quad;
  logic                         s1_zero;

  assign s1_x    = s1_q[2*DATA_WIDTH+2 -: DATA_WIDTH];
  assign s1_y    = s1_q[3 +: DATA_WIDTH];
  assign s1_quad = quadrant_e'(s1_q[2:1]);
  assign s1_zero = s1_q[0];

  // One extra bit so negating the most negative operand cannot overflow.
  logic signed [DATA_WIDTH:0]   x_ext;
  logic signed [DATA_WIDTH:0]   y_ext;
  logic signed [DATA_WIDTH:0]   rot_x;
  logic signed [DATA_WIDTH:0]   rot_y;
  logic signed [DATA_WIDTH-1:0] rot_off;
  logic                         unused_lsb;

  assign x_ext = {s1_x[DATA_WIDTH-1], s1_x};
  assign y_ext = {s1_y[DATA_WIDTH-1], s1_y};

  always_comb begin
    rot_x   = x_ext;
    rot_y   = y_ext;
    rot_off = '0;
    unique case (s1_quad)
      Q_PASS: ;
      Q_POS90: begin
        rot_x   = y_ext;
        rot_y   = -x_ext;
        rot_off = OFF_POS90;
      end
      Q_NEG90: begin
        rot_x   = -y_ext;
        rot_y   = x_ext;
        rot_off = OFF_NEG90;
      end
      default: ;
    endcase
  end

  // Dropping bit 0 is the arithmetic halving; the result always fits DATA_WIDTH.
  assign unused_lsb = ^{rot_x[0], rot_y[0]};

  // Stage 2: rotated, halved result drives the outputs.
  logic [S2W-1:0] s2_d;
  logic [S2W-1:0] s2_q;

  assign s2_d = {rot_x[DATA_WIDTH:1], rot_y[DATA_WIDTH:1], rot_off, s1_zero};

  cordic_pipe_reg #(
    .WIDTH(S2W)
  ) u_s2 (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (s1_valid),
    .in_ready (s2_in_ready),
    .in_data  (s2_d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (s2_q)
  );

  assign out_x        = s2_q[2*DATA_WIDTH+1 +: DATA_WIDTH];
  assign out_y        = s2_q[DATA_WIDTH+1 +: DATA_WIDTH];
  assign out_z_offset = s2_q[1 +: DATA_WIDTH];
  assign out_zero     = s2_q[0];

  logic [15:0] count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (out_valid && out_ready) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign out_count = count_q;

endmodule

// File: tb/tb_cordic_pre_rotator.sv
// Bench for cordic_pre_rotator: directed corner vectors plus randomized streams
// checked against a quadrant-folding reference model.
module tb_cordic_pre_rotator;

  localparam int DW = 32;
  localparam int FB = 16;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_x = '0;
  logic signed [DW-1:0] in_y = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [DW-1:0] out_x;
  logic signed [DW-1:0] out_y;
  logic signed [DW-1:0] out_z_offset;
  logic                 out_zero;
  logic [15:0]          out_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  cordic_pre_rotator #(
    .DATA_WIDTH(DW),
    .FRAC_BITS (FB)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_z_offset(out_z_offset),
    .out_zero    (out_zero),
    .out_count   (out_count)
  );

  typedef struct {
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] y;
    logic signed [DW-1:0] off;
    logic                 z;
    int                   cyc;
  } exp_t;

  exp_t sb[$];

  function automatic longint half_floor(input longint v);
    if (v >= 0) return v / 2;
    return -((-v + 1) / 2);
  endfunction

  // Rotate the vector by a multiple of 90 degrees into the half-plane x >= 0, then halve.
  function automatic exp_t model(input logic signed [DW-1:0] x, input logic signed [DW-1:0] y);
    exp_t   e;
    longint lx = longint'(x);
    longint ly = longint'(y);
    longint rx;
    longint ry;
    longint off;
    if (lx >= 0) begin
      rx = lx;  ry = ly;  off = 0;
    end else if (ly >= 0) begin
      rx = ly;  ry = -lx; off = 90 * (64'sd1 <<< FB);
    end else begin
      rx = -ly; ry = lx;  off = -90 * (64'sd1 <<< FB);
    end
    e.x   = 32'(half_floor(rx));
    e.y   = 32'(half_floor(ry));
    e.off = 32'(off);
    e.z   = (lx == 0) && (ly == 0);
    e.cyc = 0;
    return e;
  endfunction

  function automatic logic signed [DW-1:0] rand_val();
    logic signed [DW-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = 32'sh8000_0000;
      2:       v = 32'sh7fff_ffff;
      3:       v = -32'sd1;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid);
    end
    tests_run++;
    if (out_x !== 0 || out_y !== 0 || out_z_offset !== 0 || out_zero !== 1'b0 ||
        out_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_data: x=%0d y=%0d off=%0d zero=%b count=%0d expected all 0",
               out_x, out_y, out_z_offset, out_zero, out_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic signed [DW-1:0] tx[4]  = '{-32'sd100, -32'sd100, 32'sh8000_0000, 32'sd0};
    logic signed [DW-1:0] ty[4]  = '{32'sd50, -32'sd50, 32'sd0, 32'sd0};
    logic signed [DW-1:0] ex[4]  = '{32'sd25, 32'sd25, 32'sd0, 32'sd0};
    logic signed [DW-1:0] ey[4]  = '{32'sd50, -32'sd50, 32'sh4000_0000, 32'sd0};
    logic signed [DW-1:0] eo[4]  = '{32'sd5898240, 32'shFFA6_0000, 32'sd5898240, 32'sd0};
    logic                 ez[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_x      = tx[i];
      in_y      = ty[i];
      out_ready = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL directed_ready[%0d]: in_ready=%b expected 1", i, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_x !== ex[i] || out_y !== ey[i] ||
          out_z_offset !== eo[i] || out_zero !== ez[i]) begin
        tests_failed++;
        $display("FAIL directed[%0d]: got v=%b (%0d,%0d) off=%0d z=%b expected (%0d,%0d) off=%0d z=%b",
                 i, out_valid, out_x, out_y, out_z_offset, out_zero, ex[i], ey[i], eo[i], ez[i]);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_stream(input int n, input int exp_count, input string name);
    int                   sent = 0;
    int                   cyc = 0;
    bit                   accepted = 1'b0;
    bit                   hold = 1'b0;
    logic signed [DW-1:0] hx, hy, ho;
    logic                 hz;
    exp_t                 e;
    while ((sent < n || sb.size() != 0) && cyc < 4000) begin
      @(negedge clk);
      if (accepted) in_valid = 1'b0;
      accepted = 1'b0;
      if (!in_valid && sent < n && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_x     = rand_val();
        in_y     = rand_val();
      end
      out_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (hold) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_x !== hx || out_y !== hy || out_z_offset !== ho ||
            out_zero !== hz) begin
          tests_failed++;
          $display("FAIL %s_stall: got v=%b (%0d,%0d) off=%0d z=%b expected held (%0d,%0d) off=%0d z=%b",
                   name, out_valid, out_x, out_y, out_z_offset, out_zero, hx, hy, ho, hz);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL %s_extra: got unexpected output (%0d,%0d) expected none", name, out_x, out_y);
        end else begin
          e = sb.pop_front();
          if (out_x !== e.x || out_y !== e.y || out_z_offset !== e.off || out_zero !== e.z) begin
            tests_failed++;
            $display("FAIL %s_data: got (%0d,%0d) off=%0d z=%b expected (%0d,%0d) off=%0d z=%b",
                     name, out_x, out_y, out_z_offset, out_zero, e.x, e.y, e.off, e.z);
          end
        end
      end
      hold = (out_valid === 1'b1) && !out_ready;
      hx = out_x; hy = out_y; ho = out_z_offset; hz = out_zero;
      if (in_valid && in_ready === 1'b1) begin
        sb.push_back(model(in_x, in_y));
        sent++;
        accepted = 1'b1;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    tests_run++;
    if (sent != n || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_complete: got sent=%0d pending=%0d expected sent=%0d pending=0",
               name, sent, sb.size(), n);
    end
    tests_run++;
    if (out_count !== 16'(exp_count)) begin
      tests_failed++;
      $display("FAIL %s_count: got %0d expected %0d", name, out_count, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic exp_v;
    sb.delete();
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (c < 20);
      in_x      = rand_val();
      in_y      = rand_val();
      #1;
      exp_v = (c >= 2) && (c < 22);
      tests_run++;
      if (out_valid !== exp_v || (in_valid && in_ready !== 1'b1)) begin
        tests_failed++;
        $display("FAIL b2b_flow[%0d]: got out_valid=%b in_ready=%b expected out_valid=%b in_ready=1",
                 c, out_valid, in_ready, exp_v);
      end
      if (out_valid === 1'b1 && sb.size() != 0) begin
        e = sb.pop_front();
        tests_run++;
        if (out_x !== e.x || out_y !== e.y || out_z_offset !== e.off || c != e.cyc + 2) begin
          tests_failed++;
          $display("FAIL b2b_data[%0d]: got (%0d,%0d) off=%0d at cycle %0d expected (%0d,%0d) off=%0d at cycle %0d",
                   c, out_x, out_y, out_z_offset, c, e.x, e.y, e.off, e.cyc + 2);
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        e = model(in_x, in_y);
        e.cyc = c;
        sb.push_back(e);
      end
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = -32'sd100;
    in_y      = -32'sd50;
    @(negedge clk);
    in_x = 32'sd7;
    in_y = 32'sd9;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_x !== 0 || out_y !== 0 || out_z_offset !== 0 ||
        out_zero !== 1'b0 || out_count !== 16'd0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_clear: got v=%b (%0d,%0d) off=%0d z=%b cnt=%0d rdy=%b expected all 0",
               out_valid, out_x, out_y, out_z_offset, out_zero, out_count, in_ready);
    end
    @(negedge clk);
    resetn    = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset_stale[%0d]: got out_valid=%b expected 0", c, out_valid);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    sb.delete();
  endtask

  task automatic test_count_wrap();
    do_reset();
    for (int c = 0; c < 65540; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (c < 65537);
      in_x      = 32'(c);
      in_y      = -32'(c);
      #1;
      if (c == 65537) begin
        tests_run++;
        if (out_count !== 16'hFFFF) begin
          tests_failed++;
          $display("FAIL wrap_ffff: got %h expected ffff", out_count);
        end
      end else if (c == 65538) begin
        tests_run++;
        if (out_count !== 16'h0000) begin
          tests_failed++;
          $display("FAIL wrap_zero: got %h expected 0000", out_count);
        end
      end else if (c == 65539) begin
        tests_run++;
        if (out_count !== 16'h0001 || out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL wrap_one: got count=%h valid=%b expected 0001 0", out_count, out_valid);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    do_reset();
    test_stream(8, 8, "stream8");
    test_stream(300, 308, "stream300");
    test_back_to_back();
    test_reset_midflight();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cordic_pre_rotator.md
CORDIC_PRE_ROTATOR -- requirements
Module: cordic_pre_rotator

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the signed operand and angle width in bits.
REQ-002 Parameter FRAC_BITS, default 16, is the fractional bits of the angle output (degrees, Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream offers a vector.
REQ-006 in_ready  output  1  block accepts a vector this cycle.
REQ-007 in_x  input  DATA_WIDTH  signed two's-complement x.
REQ-008 in_y  input  DATA_WIDTH  signed two's-complement y.
REQ-009 out_valid  output  1  pre-rotated vector available for the CORDIC atan stage.
REQ-010 out_ready  input  1  downstream accepts the vector.
REQ-011 out_x  output  DATA_WIDTH  signed, rotated and halved x; always >= 0.
REQ-012 out_y  output  DATA_WIDTH  signed, rotated and halved y.
REQ-013 out_z_offset  output  DATA_WIDTH  signed angle offset in degrees, FRAC_BITS fraction, to add to the CORDIC result.
REQ-014 out_zero  output  1  input vector was (0,0); angle undefined.
REQ-015 out_count  output  16  count of accepted output transfers, wraps modulo 2^16.

Function
REQ-016 Transfer occurs on a side when its valid and ready are both high at a rising clk edge.
REQ-017 Two register stages: S1 captures in_x/in_y and classifies; S2 holds rotated, scaled result and drives all out_* data.
REQ-018 Latency: accepted input appears on outputs exactly 2 cycles later when out_ready is held high.
REQ-019 S2 loads when S2 empty or out_ready high; S1 loads when S1 empty or S1 moves to S2; in_ready equals that S1 load condition (combinational from out_ready permitted).
REQ-020 Full throughput: one vector per cycle with out_ready continuously high.
REQ-021 While out_valid high and out_ready low, out_* data and out_valid stay stable; no input is dropped or duplicated.
REQ-022 Classification: x>=0 -> (x,y), offset 0; x<0 and y>=0 -> (y,-x), offset +90 deg; x<0 and y<0 -> (-y,x), offset -90 deg.
REQ-023 Arithmetic: sign-extend to DATA_WIDTH+1 bits, negate where required, arithmetic shift right by 1, truncate to DATA_WIDTH; no overflow for any input, including -2^(DATA_WIDTH-1).
REQ-024 The halving gives headroom for the CORDIC gain of ~1.647; the ratio y/x, and therefore the angle, is unchanged.
REQ-025 Offset constants: +90 * 2^FRAC_BITS and its two's complement, sized to DATA_WIDTH.
REQ-026 out_zero is high, with offset 0 and out_x=out_y=0, iff in_x=0 and in_y=0.
REQ-027 out_count increments by 1 on every output transfer; 0xFFFF wraps to 0x0000.

Reset
REQ-028 resetn low asynchronously clears S1/S2 valid bits, out_valid=0, out_x=0, out_y=0, out_z_offset=0, out_zero=0, out_count=0.
REQ-029 While resetn is low, in_ready=0; it is 1 in the first cycle after release.
REQ-030 Reset mid-operation discards all in-flight vectors; no out_valid pulse follows release until new input is accepted.

Structure
REQ-031 Shared package cordic_pkg holds DATA_WIDTH/FRAC_BITS defaults, the ±90 deg offset constants, and a quadrant enum (Q_PASS, Q_POS90, Q_NEG90).
REQ-032 One sub-module, cordic_pipe_reg (valid/ready register slice), is instantiated per stage.

Verification (DATA_WIDTH=32, FRAC_BITS=16)
REQ-033 in (-100,50), out_ready=1 -> 2 cycles later out (25,50), offset 5898240, zero=0.
REQ-034 in (-100,-50) -> out (25,-50), offset -5898240 (0xFFA60000).
REQ-035 in (-2^31,0) -> out (0,2^30), offset 5898240, no overflow; in (0,0) -> out (0,0), out_zero=1, offset 0.
REQ-036 Stream 8 vectors, out_ready toggled randomly -> all 8 emerge in order, unchanged while stalled, out_count=8.
REQ-037 2 vectors in flight, resetn pulsed low -> outputs cleared immediately, no stale out_valid after release.
REQ-038 65537 transfers -> out_count=1.
